// File: rtl/ex_muldiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the front pipeline while busy.
// Optional EXMD_EARLY_OUT_EN: multiply exits once the remaining multiplier bits are all zero.
module ex_muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t state, state_nx;

  logic [2*WIDTH-1:0] prod, mcand, prod_add, prod_fix;
  logic [WIDTH-1:0]   a_reg, b_reg, rem, rs_mag, rt_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     r_tmp, diff;
  logic [CW-1:0]      count;
  logic               sign_a, sign_b, signed_op, is_div, dz;
  logic               is_signed, accept, last, mul_exit;

  // Handshake: start is a level held by EX; an op is accepted on the edge ending an
  // IDLE cycle with start=1 and flush=0. done is a one-cycle pulse in DONE.
  always_comb begin
    is_signed = ~op[0];
    rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    accept    = (state == S_IDLE) && start && !flush;
    last      = (count == CW'(WIDTH - 1));
`ifdef EXMD_EARLY_OUT_EN
    mul_exit  = last || (a_reg[WIDTH-1:1] == '0);
`else
    mul_exit  = last;
`endif
    prod_add  = a_reg[0] ? prod + mcand : prod;
    // a_reg holds the dividend and collects quotient bits as it shifts left
    r_tmp     = {rem, a_reg[WIDTH-1]};
    diff      = r_tmp - {1'b0, b_reg};
    prod_fix  = (signed_op && (sign_a ^ sign_b)) ? -prod : prod;
    quo_fix   = (signed_op && (sign_a ^ sign_b)) ? -a_reg : a_reg;
    rem_fix   = (signed_op && sign_a) ? -rem : rem;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
        if (op[1] && rt_val == '0) state_nx = S_DONE;
        else if (op[1])            state_nx = S_DIV;
        else                       state_nx = S_MUL;
      end
      S_MUL:  if (mul_exit) state_nx = S_FIX;
      S_DIV:  if (last) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0; mcand <= '0; a_reg <= '0; b_reg <= '0; rem <= '0; count <= '0;
      sign_a <= 1'b0; sign_b <= 1'b0; signed_op <= 1'b0; is_div <= 1'b0; dz <= 1'b0;
      hi <= '0; lo <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sign_a    <= is_signed & rs_val[WIDTH-1];
          sign_b    <= is_signed & rt_val[WIDTH-1];
          signed_op <= is_signed;
          is_div    <= op[1];
          dz        <= op[1] && (rt_val == '0);
          count     <= '0;
          prod      <= '0;
          rem       <= '0;
          mcand     <= {{WIDTH{1'b0}}, rs_mag};
          a_reg     <= op[1] ? rs_mag : rt_mag;
          b_reg     <= rt_mag;
        end
        S_MUL: begin
          prod  <= prod_add;
          mcand <= mcand << 1;
          a_reg <= a_reg >> 1;
          count <= count + CW'(1);
        end
        S_DIV: begin
          rem   <= diff[WIDTH] ? r_tmp[WIDTH-1:0] : diff[WIDTH-1:0];
          a_reg <= {a_reg[WIDTH-2:0], ~diff[WIDTH]};
          count <= count + CW'(1);
        end
        S_FIX: if (!flush) begin
          hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign stall       = accept || (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign div_by_zero = (state == S_DONE) && dz;
endmodule

// File: tb/tb_ex_muldiv_controller.sv
// Scoreboard bench for ex_muldiv_controller: reference results from plain 64-bit arithmetic.
module tb_ex_muldiv_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  ex_muldiv_controller #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, b,
                                        input logic [31:0] h, l);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b10: if (b == 0) return {1'b1, h, l};
             else return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) return {1'b1, h, l};
               else return {1'b0, a % b, a / b};
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] mag;
    int n;
    if (o[1] && b == 0) return 1;
    if (o[1]) return 34;
    mag = (!o[0] && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
`ifdef EXMD_EARLY_OUT_EN
    return n + 2;
`else
    return (n > 0) ? 34 : 34;
`endif
  endfunction

  task automatic monitor();
    logic [64:0] e;
    int ec;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 65'd1, 65'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("dz", {64'd0, div_by_zero}, {64'd0, e[64]});
          check("hi", {33'd0, hi}, {33'd0, e[63:32]});
          check("lo", {33'd0, lo}, {33'd0, e[31:0]});
          check("done_cycle", 65'(cyc), 65'(ec));
        end
      end
    end
  endtask

  // abort: 0 none, 1 flush at cycle abort_at, 2 reset at cycle abort_at
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                        input int abort, input int abort_at, input bit hold);
    int n, c0, lat;
    logic [64:0] e;
    @(negedge clk);
    n = 0;
    while (busy && n < 60) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 65'd1, 65'd0);
    e   = model(o, a, b, m_hi, m_lo);
    lat = latency(o, b);
    c0  = cyc;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1 check("stall_accept", {64'd0, stall}, 65'd1);
    if (abort == 0) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(c0 + lat);
      m_hi = e[63:32]; m_lo = e[31:0];
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (abort == 1 && k == abort_at) begin
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {64'd0, busy}, 65'd0);
        check("flush_hilo", {1'b0, hi, lo}, {1'b0, m_hi, m_lo});
        return;
      end
      if (abort == 2 && k == abort_at) begin
        rst = 1'b1;
        #1 check("rst_busy", {64'd0, busy}, 65'd0);
        check("rst_hilo", {1'b0, hi, lo}, 65'd0);
        m_hi = '0; m_lo = '0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k <= lat) check("stall", {64'd0, stall}, {64'd0, k < lat});
      if (k == lat + 1) begin
        check("no_reaccept", {64'd0, busy}, 65'd0);
        start = 1'b0;
        return;
      end
      if (k == lat && !hold) begin
        start = 1'b0;
        return;
      end
      rs_val = $urandom(); rt_val = $urandom(); op = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  o;
    fork monitor(); join_none
    #12;
    check("rst_hilo0", {1'b0, hi, lo}, 65'd0);
    check("rst_flags", {61'd0, stall, busy, done, div_by_zero}, 65'd0);
    rst = 1'b0;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b00, -32'sd3, 32'd5, 0, 0, 0);
    run_op(2'b10, -32'sd7, 32'd2, 0, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b11, 32'h2211, 32'h100, 0, 0, 0);
    run_op(2'b11, 32'd12345, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'd9, 32'd0, 0, 0, 0);
    run_op(2'b01, 32'd6, 32'd7, 1, 10, 0);
    run_op(2'b00, 32'd0, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'd1000, 32'd3, 2, 15, 0);
    run_op(2'b01, 32'd6, 32'd7, 0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 255));
        default: b = $urandom();
      endcase
      run_op(o, a, b, 0, 0, ($urandom_range(0, 3) == 0));
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 65'(exp_q.size()), 65'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
